// File: rtl/spin_sample_sequencer.sv
// Seven-sample spin capture sequencer for the COBI majority-vote datapath.
// Captures SPIN_IN seven times SAMPLE_GAP cycles apart, then latches the external vote.
module spin_sample_sequencer #(
  parameter int unsigned CORE_SIZE  = 64,
  parameter int unsigned SAMPLE_GAP = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CORE_SIZE-1:0]   spin_in,
  output logic [CORE_SIZE*7-1:0] sample_bus,
  input  logic [CORE_SIZE-1:0]   maj_spin,
  output logic [CORE_SIZE-1:0]   spin_out,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned NSMP  = 7;
  localparam int unsigned GAP_W = 8;
  localparam int unsigned IDX_W = 3;

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(SAMPLE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSMP - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GAP     = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;

  // Spin i, sample k lives at buf_q[i][k], i.e. flat bit i*7+k.
  logic [CORE_SIZE-1:0][NSMP-1:0] buf_q, buf_nxt;
  logic [1:0]                     state, state_nxt;
  logic [GAP_W-1:0]               gap_cnt, gap_nxt;
  logic [IDX_W-1:0]               smp_idx, idx_nxt;
  logic [CORE_SIZE-1:0]           out_nxt;
  logic                           busy_nxt, done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      buf_q    <= '0;
      gap_cnt  <= '0;
      smp_idx  <= '0;
      spin_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      buf_q    <= buf_nxt;
      gap_cnt  <= gap_nxt;
      smp_idx  <= idx_nxt;
      spin_out <= out_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    buf_nxt   = buf_q;
    gap_nxt   = gap_cnt;
    idx_nxt   = smp_idx;
    out_nxt   = spin_out;
    done_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          buf_nxt   = '0;
          gap_nxt   = GAP_LOAD;
          idx_nxt   = '0;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        // Abort wins over a capture due on the same edge.
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (gap_cnt != '0) begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end else begin
          for (int i = 0; i < CORE_SIZE; i++) begin
            buf_nxt[i][smp_idx] = spin_in[i];
          end
          if (smp_idx == IDX_LAST) begin
            state_nxt = ST_RESOLVE;
          end else begin
            idx_nxt = smp_idx + IDX_W'(1);
            gap_nxt = GAP_LOAD;
          end
        end
      end
      ST_RESOLVE: begin
        state_nxt = ST_IDLE;
        if (!abort) begin
          out_nxt  = maj_spin;
          done_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  assign sample_bus = buf_q;

endmodule

// File: doc/spin_sample_sequencer.md
# spin_sample_sequencer

Sequencer that drives the per-spin majority-vote datapath of the COBI core. On START it captures the live spin vector SPIN_IN seven times, SAMPLE_GAP cycles apart, into a CORE_SIZE×7 sample buffer. The buffer drives the combinational majority checker. One cycle after the seventh capture, the block registers the voted spin vector and pulses DONE. It sits between the oscillator-array readout and the result/readback logic.

## Interface
- CORE_SIZE, default 64: number of spins.
- SAMPLE_GAP, default 4: cycles between successive captures. Legal range 1..255.
- CLK  input  1  the single clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  request a new 7-sample vote; sampled only in IDLE.
- ABORT  input  1  synchronous cancel of an in-progress vote.
- SPIN_IN  input  CORE_SIZE  live spin phase bits from the array.
- SAMPLE_BUS  output  CORE_SIZE*7  sample buffer to the majority checker.
  - Spin i, sample k sits at bit i*7+k.
- MAJ_SPIN  input  CORE_SIZE  combinational vote returned by the majority checker.
- SPIN_OUT  output  CORE_SIZE  registered voted spin vector.
- BUSY  output  1  high in any state other than IDLE.
- DONE  output  1  one-cycle pulse when SPIN_OUT is updated.

## Operation
- States: IDLE, GAP, RESOLVE.
- IDLE
  - START=1 clears SAMPLE_BUS to 0, loads gap_cnt=SAMPLE_GAP-1, sets smp_idx=0, and enters GAP.
- GAP
  - While gap_cnt≠0: decrement gap_cnt.
  - When gap_cnt=0: write SPIN_IN[i] into bit i*7+smp_idx for all i.
    - If smp_idx=6: go to RESOLVE.
    - Otherwise: increment smp_idx, reload gap_cnt=SAMPLE_GAP-1, stay in GAP.
- RESOLVE
  - Register SPIN_OUT<=MAJ_SPIN, assert DONE for the following cycle, and return to IDLE.
- ABORT=1 in GAP or RESOLVE returns the block to IDLE on that edge.
  - No DONE, SPIN_OUT unchanged, SAMPLE_BUS holds its partial contents.
  - ABORT in IDLE has no effect.
  - ABORT has priority over capture and over the RESOLVE latch.
- START outside IDLE is ignored; it is not queued.
- START and ABORT asserted together in IDLE: START wins.
- Vote rule provided by the datapath: output 1 when four or more of the 7 samples are 1.
- Counter widths: gap_cnt is 8 bits, smp_idx is 3 bits. Neither counter wraps within a vote.
- SAMPLE_GAP=1 gives captures on consecutive edges.
- The buffer is written only at capture edges. Between captures SAMPLE_BUS is stable, so MAJ_SPIN may be treated as settled by RESOLVE.

## Timing
- Reset values, applied asynchronously on RST_N=0:
  - State=IDLE, SAMPLE_BUS=0, SPIN_OUT=0, BUSY=0, DONE=0, gap_cnt=0, smp_idx=0.
- Edge numbering: edge 0 is the rising edge at which START is sampled high in IDLE.
  - BUSY is high from after edge 0.
  - Capture k (k=0..6) occurs at edge SAMPLE_GAP*(k+1) and samples SPIN_IN as setup before that edge.
  - RESOLVE occupies the cycle after edge 7*SAMPLE_GAP.
  - At edge 7*SAMPLE_GAP+1, SPIN_OUT updates, DONE rises, BUSY falls.
  - DONE falls at edge 7*SAMPLE_GAP+2.
- Total latency from START edge to DONE: 7*SAMPLE_GAP+1 cycles.
- Back-to-back votes: START may be high during the DONE cycle; the new vote's edge 0 is edge 7*SAMPLE_GAP+2.
- Reset mid-vote: all state clears immediately; no DONE is produced. After release, the block waits in IDLE for START.

## Test plan
- SAMPLE_GAP=4, SPIN_IN[0]=1 constant, all other bits 0, START pulse.
  - Required: SAMPLE_BUS[6:0]=7'h7F at edge 28; SPIN_OUT[0]=1, others 0; DONE high for exactly one cycle after edge 29.
- SAMPLE_GAP=4, SPIN_IN[1] driven 1,0,1,0,1,0,1 at the capture edges, and SPIN_IN[2] driven 0,1,0,1,0,1,0.
  - Required: SAMPLE_BUS[13:7]=7'b1010101 and SAMPLE_BUS[20:14]=7'b0101010.
  - Required: SPIN_OUT[1]=1 and SPIN_OUT[2]=0.
- SAMPLE_GAP=1, random SPIN_IN per edge.
  - Required: captures on edges 1..7, DONE after edge 8, SPIN_OUT equal to a reference popcount≥4 model.
- START re-asserted at edges 3 and 10 during a vote with SAMPLE_GAP=4.
  - Required: ignored; a single DONE after edge 29; BUSY stays high throughout.
- ABORT at edge 13 with SAMPLE_GAP=4, prior SPIN_OUT=0xA5 pattern.
  - Required: state returns to IDLE; BUSY=0 after edge 13; no DONE; SPIN_OUT unchanged; a new START then completes normally.
- RST_N pulled low mid-cycle around edge 17.
  - Required: SAMPLE_BUS=0, SPIN_OUT=0, BUSY=0, DONE=0 immediately, without waiting for CLK; no DONE after release.
